uint8_div: RTL and testbench

- Sequential unsigned divider: the inverse operation of the team's combinational unsigned multiplier.
- Computes quotient and remainder of two DWIDTH-bit unsigned operands by restoring division, one quotient bit per clock.
- Uses a valid/ready handshake on both input and output, so it can sit in the same datapath as the multiplier.
- Consumers include the complex-multiplier normalisation and scaling stages.

---
 rtl/uint8_div.sv | 137 +++++++++++++
 tb/tb_uint8_div.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uint8_div.sv
// Sequential restoring divider: one quotient bit per clock, valid/ready on both sides.
// Optional divide-by-zero flag output is enabled by defining DIV_ZERO_FLAG_EN.
module uint8_div #(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_val,
    output logic              op_rdy,
    input  logic [DWIDTH-1:0] dividend,
    input  logic [DWIDTH-1:0] divisor,
    output logic              res_val,
    input  logic              res_rdy,
    output logic [DWIDTH-1:0] quotient,
    output logic [DWIDTH-1:0] remainder
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic              div_by_zero
`endif
);

    localparam int CW = $clog2(DWIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic accept;
    logic retire;
    logic last_step;

    logic [DWIDTH-1:0] dvd_q;   // dividend shift register, fills with quotient bits
    logic [DWIDTH-1:0] dvs_q;
    logic [DWIDTH-1:0] rem_q;   // restored partial remainder, always < divisor
    logic [CW-1:0]     cnt_q;

    logic [DWIDTH:0]   shifted;
    logic [DWIDTH:0]   trial;
    logic              q_bit;
    logic [DWIDTH-1:0] rem_nxt;
    logic [DWIDTH-1:0] dvd_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        op_rdy    = 1'b0;
        res_val   = 1'b0;
        accept    = 1'b0;
        retire    = 1'b0;
        last_step = 1'b0;
        case (state)
            IDLE: begin
                op_rdy = 1'b1;
                if (op_val) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    last_step = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                res_val = 1'b1;
                if (res_rdy) begin
                    retire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One restoring step: the subtractor is DWIDTH+1 bits so its MSB is the borrow.
    always_comb begin
        shifted = {rem_q, dvd_q[DWIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        q_bit   = ~trial[DWIDTH];
        rem_nxt = q_bit ? trial[DWIDTH-1:0] : shifted[DWIDTH-1:0];
        dvd_nxt = {dvd_q[DWIDTH-2:0], q_bit};
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            if (accept) begin
                dvd_q <= dividend;
                dvs_q <= divisor;
                rem_q <= '0;
                cnt_q <= CW'(DWIDTH - 1);
            end else if (state == CALC) begin
                dvd_q <= dvd_nxt;
                rem_q <= rem_nxt;
                cnt_q <= cnt_q - CW'(1);
            end
            // Result registers load only on the final step, so they hold through DONE.
            if (last_step) begin
                quotient  <= dvd_nxt;
                remainder <= rem_nxt;
            end
        end
    end

`ifdef DIV_ZERO_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            div_by_zero <= 1'b0;
        end else if (accept) begin
            div_by_zero <= (divisor == '0);
        end else if (retire) begin
            div_by_zero <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uint8_div.sv
// Randomised self-checking bench for uint8_div against an arithmetic reference model.
module tb_uint8_div;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_val;
    logic         op_rdy;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         res_val;
    logic         res_rdy;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
    logic         div_by_zero;
`endif

    int checks = 0;
    int errors = 0;

    uint8_div #(.DWIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_val    (op_val),
        .op_rdy    (op_rdy),
        .dividend  (dividend),
        .divisor   (divisor),
        .res_val   (res_val),
        .res_rdy   (res_rdy),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .div_by_zero (div_by_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one division, hold the result for 'stall' cycles, then retire it.
    task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d, input int stall, input string tag);
        int           lat;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        eq = (d == 0) ? {W{1'b1}} : W'(n / d);
        er = (d == 0) ? n : W'(n % d);

        lat = 0;
        while (!op_rdy && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "/op_rdy_idle"}, 32'(op_rdy), 32'd1);

        dividend = n;
        divisor  = d;
        op_val   = 1'b1;
        tick();
        op_val   = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        check({tag, "/op_rdy_calc"}, 32'(op_rdy), 32'd0);

        lat = 0;
        while (!res_val && lat < 4 * W) begin
            tick();
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(W));
        check({tag, "/q"}, 32'(quotient), 32'(eq));
        check({tag, "/r"}, 32'(remainder), 32'(er));
        check({tag, "/op_rdy_done"}, 32'(op_rdy), 32'd0);
        if (d != 0) begin
            check({tag, "/q*d+r"}, 32'(quotient) * 32'(d) + 32'(remainder), 32'(n));
            check({tag, "/r<d"}, 32'(remainder < d), 32'd1);
        end
`ifdef DIV_ZERO_FLAG_EN
        check({tag, "/dbz"}, 32'(div_by_zero), 32'(d == 0));
`endif

        for (int i = 0; i < stall; i++) begin
            res_rdy  = 1'b0;
            op_val   = 1'($urandom_range(0, 1));
            dividend = W'($urandom);
            divisor  = W'($urandom);
            tick();
            check({tag, "/hold_val"}, 32'(res_val), 32'd1);
            check({tag, "/hold_q"}, 32'(quotient), 32'(eq));
            check({tag, "/hold_r"}, 32'(remainder), 32'(er));
            check({tag, "/hold_rdy"}, 32'(op_rdy), 32'd0);
        end

        op_val  = 1'b0;
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
        check({tag, "/retire_val"}, 32'(res_val), 32'd0);
        check({tag, "/retire_rdy"}, 32'(op_rdy), 32'd1);
`ifdef DIV_ZERO_FLAG_EN
        check({tag, "/retire_dbz"}, 32'(div_by_zero), 32'd0);
`endif
    endtask

    initial begin
        rst      = 1'b1;
        op_val   = 1'b0;
        res_rdy  = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset/op_rdy", 32'(op_rdy), 32'd1);
        check("reset/res_val", 32'(res_val), 32'd0);
        check("reset/q", 32'(quotient), 32'd0);
        check("reset/r", 32'(remainder), 32'd0);
`ifdef DIV_ZERO_FLAG_EN
        check("reset/dbz", 32'(div_by_zero), 32'd0);
`endif

        run_op(8'd200, 8'd7,   0, "basic");
        run_op(8'd255, 8'd1,   0, "255/1");
        run_op(8'd5,   8'd9,   0, "5/9");
        run_op(8'd255, 8'd255, 0, "255/255");
        run_op(8'd0,   8'd13,  0, "0/13");
        run_op(8'd100, 8'd0,   0, "100/0");
        run_op(8'd100, 8'd4,   0, "100/4");
        run_op(8'd150, 8'd11,  5, "bp");

        // Reset at the fourth CALC step discards the in-flight 77/3.
        dividend = 8'd77;
        divisor  = 8'd3;
        op_val   = 1'b1;
        tick();
        op_val = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst/op_rdy", 32'(op_rdy), 32'd1);
        check("midrst/res_val", 32'(res_val), 32'd0);
        check("midrst/q", 32'(quotient), 32'd0);
        check("midrst/r", 32'(remainder), 32'd0);
        run_op(8'd77, 8'd3, 0, "77/3");

        for (int k = 0; k < 2000; k++) begin
            run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), $urandom_range(0, 3), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
